// File: rtl/pow_n_pipe_flow_pkg.sv
// Shared helpers for the pow_n_pipe_flow power pipeline.
package pow_n_pipe_flow_pkg;

  // Bits needed to count 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pow_n_pipe_flow_stage.sv
// One multiply stage of the power pipeline with a valid/ready skid-free handshake.
module pow_n_pipe_flow_stage
  import pow_n_pipe_flow_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_p,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_p,
  output logic         rdy
);

  logic [W-1:0] prod;

  assign prod = in_p * in_a;

  // An empty stage always accepts, so bubbles collapse under backpressure.
  assign rdy = !out_vld || out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_a   <= '0;
      out_p   <= '0;
    end else if (rdy) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_a <= in_a;
        out_p <= prod;
      end
    end
  end

endmodule

// File: rtl/pow_n_pipe_flow.sv
// Pipelined arg^(N_STAGES+1) mod 2^W with valid/ready backpressure and an occupancy count.
module pow_n_pipe_flow
  import pow_n_pipe_flow_pkg::*;
#(
  parameter int W        = 8,
  parameter int N_STAGES = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            arg_vld,
  output logic                            arg_rdy,
  input  logic [W-1:0]                    arg,
  output logic                            res_vld,
  input  logic                            res_rdy,
  output logic [W-1:0]                    res,
  output logic [N_STAGES-1:0]             stage_vld,
  output logic [N_STAGES*W-1:0]           stage_res,
  output logic [clog2(N_STAGES+1)-1:0]    occupancy
);

  localparam int OCC_W = clog2(N_STAGES + 1);

  logic         vld_chain [0:N_STAGES];
  logic         rdy_chain [1:N_STAGES+1];
  logic [W-1:0] a_chain   [0:N_STAGES];
  logic [W-1:0] p_chain   [0:N_STAGES];
  logic         in_xfer;
  logic         out_xfer;

  // Stage 1 squares the base, so both of its operands are arg.
  assign vld_chain[0]          = arg_vld;
  assign a_chain[0]            = arg;
  assign p_chain[0]            = arg;
  assign rdy_chain[N_STAGES+1] = res_rdy;

  for (genvar k = 1; k <= N_STAGES; k++) begin : g_stage
    pow_n_pipe_flow_stage #(.W(W)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (vld_chain[k-1]),
      .in_a    (a_chain[k-1]),
      .in_p    (p_chain[k-1]),
      .out_rdy (rdy_chain[k+1]),
      .out_vld (vld_chain[k]),
      .out_a   (a_chain[k]),
      .out_p   (p_chain[k]),
      .rdy     (rdy_chain[k])
    );

    assign stage_vld[k-1]       = vld_chain[k];
    assign stage_res[k*W-1 -: W] = p_chain[k];
  end

  assign arg_rdy  = rdy_chain[1];
  assign res_vld  = vld_chain[N_STAGES];
  assign res      = p_chain[N_STAGES];
  assign in_xfer  = arg_vld && arg_rdy;
  assign out_xfer = res_vld && res_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_n_pipe_flow.sv
// Self-checking bench: queue-based timing/value model for two pow_n_pipe_flow configurations.
module tb_pow_n_pipe_flow;

  localparam int W0 = 8;
  localparam int N0 = 4;
  localparam int W1 = 16;
  localparam int N1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic            a_vld0, a_rdy0, r_vld0, r_rdy0;
  logic [W0-1:0]   a0, r0;
  logic [N0-1:0]   sv0;
  logic [N0*W0-1:0] sr0;
  logic [2:0]      occ0;

  logic            a_vld1, a_rdy1, r_vld1, r_rdy1;
  logic [W1-1:0]   a1, r1;
  logic [N1-1:0]   sv1;
  logic [N1*W1-1:0] sr1;
  logic [0:0]      occ1;

  pow_n_pipe_flow #(.W(W0), .N_STAGES(N0)) dut0 (
    .clk(clk), .rst_n(rst_n), .arg_vld(a_vld0), .arg_rdy(a_rdy0), .arg(a0),
    .res_vld(r_vld0), .res_rdy(r_rdy0), .res(r0), .stage_vld(sv0),
    .stage_res(sr0), .occupancy(occ0)
  );

  pow_n_pipe_flow #(.W(W1), .N_STAGES(N1)) dut1 (
    .clk(clk), .rst_n(rst_n), .arg_vld(a_vld1), .arg_rdy(a_rdy1), .arg(a1),
    .res_vld(r_vld1), .res_rdy(r_rdy1), .res(r1), .stage_vld(sv1),
    .stage_res(sr1), .occupancy(occ1)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt++;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  function automatic longint pw(input longint a, input int e, input int w);
    longint r;
    longint m;
    m = (longint'(1) << w) - 1;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * (a & m)) & m;
    return r;
  endfunction

  // Model: in-flight args in FIFO order with their accept edge. An item can
  // show at the output once it has crossed N stages and its predecessor left.
  int q0_a[$], q0_n[$], last0 = 0;
  int q1_a[$], q1_n[$], last1 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q0_a.delete(); q0_n.delete(); last0 = 0;
    end else begin
      bit ev, er;
      ev = 1'b0;
      if (q0_a.size() > 0)
        ev = (ecnt >= q0_n[0] + N0 - 1) && (ecnt >= last0);
      er = !(q0_a.size() == N0 && !r_rdy0);
      check("d0_arg_rdy", a_rdy0, er);
      check("d0_res_vld", r_vld0, ev);
      if (ev) check("d0_res", r0, pw(q0_a[0], N0 + 1, W0));
      check("d0_occupancy", occ0, q0_a.size());
      check("d0_popcount", $countones(sv0), q0_a.size());
      if (ev && r_rdy0) begin
        void'(q0_a.pop_front()); void'(q0_n.pop_front()); last0 = ecnt + 1;
      end
      if (a_vld0 && er) begin
        q0_a.push_back(int'(a0)); q0_n.push_back(ecnt + 1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q1_a.delete(); q1_n.delete(); last1 = 0;
    end else begin
      bit ev, er;
      ev = 1'b0;
      if (q1_a.size() > 0)
        ev = (ecnt >= q1_n[0] + N1 - 1) && (ecnt >= last1);
      er = !(q1_a.size() == N1 && !r_rdy1);
      check("d1_arg_rdy", a_rdy1, er);
      check("d1_res_vld", r_vld1, ev);
      if (ev) check("d1_res", r1, pw(q1_a[0], N1 + 1, W1));
      check("d1_occupancy", occ1, q1_a.size());
      check("d1_popcount", $countones(sv1), q1_a.size());
      if (ev && r_rdy1) begin
        void'(q1_a.pop_front()); void'(q1_n.pop_front()); last1 = ecnt + 1;
      end
      if (a_vld1 && er) begin
        q1_a.push_back(int'(a1)); q1_n.push_back(ecnt + 1);
      end
    end
  end

  int log0[$], log0_t[$];
  always @(negedge clk) begin
    if (rst_n && r_vld0 && r_rdy0) begin
      log0.push_back(int'(r0));
      log0_t.push_back(ecnt);
    end
  end

  task automatic check_log0(input string nm, input int exp[$]);
    check({nm, "_count"}, log0.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log0.size(); i++) check(nm, log0[i], exp[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1[4];
    int eq[$];
    bit got;

    a_vld0 = 0; a0 = '0; r_rdy0 = 1;
    a_vld1 = 0; a1 = '0; r_rdy1 = 1;
    rst_n = 0;
    #2;
    check("reset_occ", occ0, 0);
    check("reset_res_vld", r_vld0, 0);
    check("reset_res", r0, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    step();

    // single op: 3 -> 9, 27, 81, 243
    e1 = '{9, 27, 81, 243};
    a_vld0 = 1; a0 = 8'd3; step();
    a_vld0 = 0; a0 = W0'($urandom);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_stage_vld", sv0[k], 1);
      check("t1_stage_res", sr0[(k+1)*W0-1 -: W0], e1[k]);
      if (k == 3) check("t1_res", r0, 8'hF3);
      step();
    end
    @(negedge clk);
    check("t1_res_vld_drop", r_vld0, 0);
    check("t1_occ_zero", occ0, 0);
    step();

    // streaming at full rate
    log0.delete(); log0_t.delete();
    eq = '{2, 5, 0, 1, 255};
    foreach (eq[i]) begin
      a_vld0 = 1; a0 = W0'(eq[i]); step();
    end
    a_vld0 = 0;
    idle(8);
    eq = '{32, 53, 0, 1, 255};
    check_log0("t2_seq", eq);
    if (log0_t.size() == 5) check("t2_back_to_back", log0_t[4] - log0_t[0], 4);

    // backpressure: four fill the pipe, fifth waits
    log0.delete(); log0_t.delete();
    r_rdy0 = 0;
    for (int v = 1; v <= 4; v++) begin
      a_vld0 = 1; a0 = W0'(v); step();
    end
    a0 = 8'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_arg_rdy_low", a_rdy0, 0);
      check("t3_occ_full", occ0, 4);
      check("t3_res_held", r0, 1);
      step();
    end
    r_rdy0 = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      got = a_rdy0;
      step();
    end
    a_vld0 = 0;
    check("t3_accept_5", got, 1);
    idle(8);
    eq = '{1, 32, 243, 0, 53};
    check_log0("t3_seq", eq);

    // bubble collapse: 7, two idle cycles, 9, output stalled
    log0.delete(); log0_t.delete();
    r_rdy0 = 0;
    a_vld0 = 1; a0 = 8'd7; step();
    a_vld0 = 0; idle(2);
    a_vld0 = 1; a0 = 8'd9; step();
    a_vld0 = 0; idle(5);
    @(negedge clk);
    check("t4_occ", occ0, 2);
    check("t4_stage_vld", sv0, 4'b1100);
    check("t4_stage4", sr0[31:24], 8'd167);  // 7^5 = 16807
    check("t4_stage3", sr0[23:16], 8'd161);  // 9^4 = 6561
    step();
    r_rdy0 = 1;
    idle(4);
    eq = '{167, 169};                        // 9^5 = 59049
    check_log0("t4_seq", eq);

    // asynchronous reset with three in flight
    log0.delete(); log0_t.delete();
    r_rdy0 = 0;
    for (int v = 10; v <= 12; v++) begin
      a_vld0 = 1; a0 = W0'(v); step();
    end
    a_vld0 = 0;
    #1 rst_n = 0;
    #1;
    check("t5_stage_vld_clr", sv0, 0);
    check("t5_res_vld_clr", r_vld0, 0);
    check("t5_occ_clr", occ0, 0);
    @(posedge clk);
    #2 rst_n = 1;
    step();
    r_rdy0 = 1;
    idle(6);
    check("t5_no_stale", log0.size(), 0);
    a_vld0 = 1; a0 = 8'd3; step();
    a_vld0 = 0;
    idle(6);
    eq = '{243};
    check_log0("t5_after_reset", eq);

    // W=16, N_STAGES=1: registered square
    r_rdy1 = 1;
    a_vld1 = 1; a1 = 16'd300; step();
    a_vld1 = 0;
    @(negedge clk);
    check("t6_res_vld", r_vld1, 1);
    check("t6_res", r1, 16'd24464);
    step();
    @(negedge clk);
    check("t6_res_vld_drop", r_vld1, 0);
    step();

    // random valid/ready on both configurations
    for (int i = 0; i < 3000; i++) begin
      a_vld0 = ($urandom_range(0, 3) != 0);
      a0     = W0'($urandom);
      r_rdy0 = ($urandom_range(0, 2) != 0);
      a_vld1 = ($urandom_range(0, 1) != 0);
      a1     = W1'($urandom);
      r_rdy1 = ($urandom_range(0, 2) != 0);
      step();
    end
    a_vld0 = 0; a_vld1 = 0; r_rdy0 = 1; r_rdy1 = 1;
    idle(10);
    @(negedge clk);
    check("drain_occ0", occ0, 0);
    check("drain_occ1", occ1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
